fpquot_seq: RTL
===============

FPQUOT_SEQ -- requirements
Module: fpquot_seq

Interface
REQ-001 SHALL have parameter N, default 32, total word width.
REQ-002 SHALL have parameter Q, default 16, fractional bits (Q16.16 sign-magnitude: bit N-1 sign, bits N-2:0 magnitude).
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles before abort.
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-007 SHALL have port num  input  N  dividend, sampled with start.
REQ-008 SHALL have port den  input  N  divisor, sampled with start.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port quot  output  N  quotient; held stable from done until the next done.
REQ-012 SHALL have port dz  output  1  divide-by-zero flag, valid with done.
REQ-013 SHALL have port err  output  1  reciprocal-unit timeout flag, valid with done.
REQ-014 SHALL have port div_start  output  1  one-cycle request to the reciprocal unit.
REQ-015 SHALL have port div_in  output  N  operand to the reciprocal unit (latched den, sign included).
REQ-016 SHALL have port div_ans  input  N  reciprocal result, valid in the div_done cycle.
REQ-017 SHALL have port div_done  input  1  one-cycle completion pulse from the reciprocal unit.

Function
REQ-018 SHALL implement Moore FSM states IDLE, ISSUE, WAIT, MUL, FIN.
REQ-019 IDLE SHALL go to ISSUE when start=1 and magnitude of den is nonzero, latching num and den.
REQ-020 IDLE SHALL go to MUL with dz set when start=1 and den[N-2:0]=0; no div_start is issued.
REQ-021 ISSUE SHALL assert div_start for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-022 WAIT SHALL capture div_ans into the reciprocal register and go to MUL on div_done=1.
REQ-023 WAIT SHALL increment the timeout counter each cycle; at count = TIMEOUT it SHALL go to MUL with err set.
REQ-024 MUL SHALL register quot as follows: normal case, the Q-scaled sign-magnitude product num_r * recip_r; dz case, magnitude all ones with sign num_r[N-1]; err case, 0.
REQ-025 Product sign SHALL be the XOR of the operand signs; product magnitude SHALL be bits [N-2+Q:Q] of the full product, truncated and not rounded.
REQ-026 FIN SHALL assert done for one cycle and go to IDLE.
REQ-027 In the normal case, done SHALL occur 2 cycles after the div_done cycle. In the dz case, done SHALL occur 2 cycles after the start cycle.
REQ-028 start SHALL be ignored outside IDLE; a new request is accepted no earlier than the cycle after FIN.
REQ-029 div_done SHALL be ignored in every state except WAIT, including late pulses after a timeout.
REQ-030 dz and err SHALL be cleared on each accepted start and held until the next accepted start.
REQ-031 div_in SHALL be driven from the latched den and held stable from ISSUE through WAIT.

Reset
REQ-032 rst=0 SHALL force IDLE with busy=0, done=0, div_start=0, dz=0, err=0, quot=0, div_in=0 and timeout counter=0, in any state including mid-WAIT.
REQ-033 After reset release, the block SHALL accept start on the first clk edge.

Structure
REQ-034 A shared package SHALL hold the state encoding, the Q16.16 constants (ONE=0x00010000, SAT=0x7FFFFFFF) and the default TIMEOUT.
REQ-035 The fixed-point multiply SHALL be the single sub-module qmult #(Q,N), driven from registered operands.
REQ-036 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide.

Verification
REQ-037 Normal case: num=0x00030000 (3.0), den=0x00020000; model returns div_ans=0x00008000 20 cycles after div_start -> div_in=0x00020000, one div_start pulse, quot=0x00018000, done 2 cycles after div_done, dz=err=0.
REQ-038 Sign case: num=0x80030000 (-3.0), den=0x00020000, div_ans=0x00008000 -> quot=0x80018000.
REQ-039 Divide-by-zero: num=0x80010000, den=0x80000000 -> no div_start, done 2 cycles after start, quot=0xFFFFFFFF, dz=1.
REQ-040 Timeout: model never asserts div_done -> done at WAIT cycle TIMEOUT+2, err=1, quot=0; a later div_done pulse causes no change.
REQ-041 Start during WAIT is ignored (only one div_start seen); rst=0 mid-WAIT -> all outputs at reset values; the next start completes normally.

Source files
------------

// File: rtl/fpquot_seq_pkg.sv
// Shared definitions for the sequential sign-magnitude fixed-point quotient unit.
// Holds the state encoding, the Q16.16 constants and the default reciprocal-unit timeout.
package fpquot_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    MUL   = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic [31:0] ONE = 32'h0001_0000;
  localparam logic [31:0] SAT = 32'h7FFF_FFFF;

  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/fpquot_seq_qmult.sv
// Sign-magnitude fixed-point multiplier: sign is the XOR of the operand signs,
// magnitude is the Q-scaled middle slice of the full product (truncated).
module qmult #(
  parameter int Q = 16,
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  logic [2*N-3:0] full;
  logic           unused_bits;

  assign full = a[N-2:0] * b[N-2:0];
  assign y    = {a[N-1] ^ b[N-1], full[N-2+Q:Q]};

  // Fraction bits below Q and overflow bits above the kept window are dropped.
  assign unused_bits = ^{full[Q-1:0], full[2*N-3:N-1+Q]};

endmodule

// File: rtl/fpquot_seq.sv
// Sequential quotient num/den: requests 1/den from an external reciprocal unit,
// then multiplies num by the returned reciprocal. Flags divide-by-zero and timeout.
module fpquot_seq
  import fpquot_seq_pkg::*;
#(
  parameter int N       = 32,
  parameter int Q       = 16,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] num,
  input  logic [N-1:0] den,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quot,
  output logic         dz,
  output logic         err,
  output logic         div_start,
  output logic [N-1:0] div_in,
  input  logic [N-1:0] div_ans,
  input  logic         div_done
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  state_t         state_reg;
  logic [N-1:0]   num_reg;
  logic [N-1:0]   den_reg;
  logic [N-1:0]   recip_reg;
  logic [N-1:0]   quot_reg;
  logic [CW-1:0]  cnt_reg;
  logic           busy_reg;
  logic           done_reg;
  logic           dz_reg;
  logic           err_reg;
  logic           div_start_reg;
  logic [N-1:0]   prod;

  qmult #(.Q(Q), .N(N)) u_qmult (
    .a (num_reg),
    .b (recip_reg),
    .y (prod)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      num_reg       <= '0;
      den_reg       <= '0;
      recip_reg     <= '0;
      quot_reg      <= '0;
      cnt_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      dz_reg        <= 1'b0;
      err_reg       <= 1'b0;
      div_start_reg <= 1'b0;
    end else begin
      done_reg      <= 1'b0;
      div_start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            num_reg  <= num;
            den_reg  <= den;
            dz_reg   <= 1'b0;
            err_reg  <= 1'b0;
            busy_reg <= 1'b1;
            // A zero magnitude skips the reciprocal unit entirely.
            if (den[N-2:0] == '0) begin
              dz_reg    <= 1'b1;
              state_reg <= MUL;
            end else begin
              div_start_reg <= 1'b1;
              state_reg     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt_reg   <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (div_done) begin
            recip_reg <= div_ans;
            state_reg <= MUL;
          end else if (cnt_reg == CNT_MAX) begin
            err_reg   <= 1'b1;
            state_reg <= MUL;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        MUL: begin
          if (err_reg)
            quot_reg <= '0;
          else if (dz_reg)
            quot_reg <= {num_reg[N-1], {(N-1){1'b1}}};
          else
            quot_reg <= prod;
          done_reg  <= 1'b1;
          state_reg <= FIN;
        end
        FIN: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign quot      = quot_reg;
  assign dz        = dz_reg;
  assign err       = err_reg;
  assign div_start = div_start_reg;
  assign div_in    = den_reg;

endmodule
